// File: rtl/seqdet_pkg.sv
// Shared types and limits for the parametrised serial sequence detector.
package seqdet_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } seqdet_state_t;

    localparam int SEQDET_MAX_LEN = 16;
    localparam int SEQDET_MIN_LEN = 2;

endpackage

// File: rtl/seqdet_sat_counter.sv
// Generic saturating up-counter: counts enabled cycles and holds at all-ones.
module seqdet_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             inc_en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (inc_en && (count_reg != {WIDTH{1'b1}})) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector with run-time reloadable pattern and one-cycle match pulse.
// Optional saturating match counter is built when SEQDET_MATCH_COUNT_EN is defined.
module seq_detector_param
    import seqdet_pkg::*;
#(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic               x_in,
    input  logic               x_valid,
    input  logic               pat_load,
    input  logic [PAT_LEN-1:0] pat_in,
    output logic               y_out,
    output logic [CNT_W-1:0]   match_count
);

    localparam int                FILL_W    = $clog2(PAT_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_LEN - 1);

    generate
        if ((PAT_LEN < SEQDET_MIN_LEN) || (PAT_LEN > SEQDET_MAX_LEN)) begin : g_len_check
            $error("seq_detector_param: PAT_LEN out of range");
        end
    endgenerate

    seqdet_state_t      state_reg, state_next;
    logic [FILL_W-1:0]  fill_reg, fill_next;
    // The oldest accepted bit is shifted out before any compare, so only PAT_LEN-1 are kept.
    logic [PAT_LEN-2:0] hist_reg, hist_next;
    logic [PAT_LEN-1:0] pat_reg, pat_next;
    logic               y_reg, y_next;

    logic [PAT_LEN-1:0] shifted;
    logic               completes;
    logic               match_hit;

    assign shifted   = {hist_reg, x_in};
    assign completes = (state_reg == ARMED) || (fill_reg == FILL_LAST);
    assign match_hit = x_valid && !pat_load && completes && (shifted == pat_reg);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_reg <= FILL;
            fill_reg  <= '0;
            hist_reg  <= '0;
            pat_reg   <= PATTERN;
            y_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            fill_reg  <= fill_next;
            hist_reg  <= hist_next;
            pat_reg   <= pat_next;
            y_reg     <= y_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        fill_next  = fill_reg;
        hist_next  = hist_reg;
        pat_next   = pat_reg;
        y_next     = 1'b0;

        if (pat_load) begin
            pat_next   = pat_in;
            hist_next  = '0;
            fill_next  = '0;
            state_next = FILL;
        end else if (x_valid) begin
            hist_next = shifted[PAT_LEN-2:0];
            if (fill_reg != FILL_FULL) begin
                fill_next = fill_reg + FILL_W'(1);
            end
            if (completes) begin
                state_next = ARMED;
            end
            if (match_hit) begin
                y_next = 1'b1;
                // Non-overlapping mode discards the window, but the history still shifts.
                if (!OVERLAP) begin
                    fill_next  = '0;
                    state_next = FILL;
                end
            end
        end
    end

    assign y_out = y_reg;

`ifdef SEQDET_MATCH_COUNT_EN
    logic [CNT_W-1:0] cnt;

    seqdet_sat_counter #(
        .WIDTH (CNT_W)
    ) u_match_cnt (
        .clk    (CLK),
        .srst   (Reset),
        .inc_en (match_hit),
        .count  (cnt)
    );

    assign match_count = cnt;
`else
    assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: three instances (overlap, non-overlap, 2-bit saturating)
// checked each cycle against an accepted-bit log model plus hand-computed literals.
module tb_seq_detector_param;

`ifdef SEQDET_MATCH_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic CLK_TB = 1'b0;
    always #5 CLK_TB = ~CLK_TB;

    logic       reset;
    logic       x_in;
    logic       x_valid;
    logic       pat_load;
    logic [3:0] pat_in;

    logic       y_ov, y_nov, y_sat;
    logic [7:0] c_ov, c_nov;
    logic [1:0] c_sat;

    seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) dut_ov (
        .CLK(CLK_TB), .Reset(reset), .x_in(x_in), .x_valid(x_valid),
        .pat_load(pat_load), .pat_in(pat_in), .y_out(y_ov), .match_count(c_ov)
    );

    seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) dut_nov (
        .CLK(CLK_TB), .Reset(reset), .x_in(x_in), .x_valid(x_valid),
        .pat_load(pat_load), .pat_in(pat_in), .y_out(y_nov), .match_count(c_nov)
    );

    seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(2)) dut_sat (
        .CLK(CLK_TB), .Reset(reset), .x_in(x_in), .x_valid(x_valid),
        .pat_load(pat_load), .pat_in(pat_in), .y_out(y_sat), .match_count(c_sat)
    );

    // Model: a log of bits accepted since the last clear; a match is the last four
    // logged bits spelling the pattern (oldest bit = pattern MSB).
    bit         m_ov[3]    = '{1'b1, 1'b0, 1'b1};
    int         m_cap[3]   = '{255, 255, 3};
    logic [3:0] m_reset[3] = '{4'b1011, 4'b1011, 4'b1111};
    logic [3:0] m_pat[3];
    bit         acc[3][64];
    int         accn[3];
    bit         ey[3];
    int         ecnt[3];

    always @(posedge CLK_TB) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                accn[k]  = 0;
                m_pat[k] = m_reset[k];
                ey[k]    = 1'b0;
                ecnt[k]  = 0;
            end else if (pat_load) begin
                accn[k]  = 0;
                m_pat[k] = pat_in;
                ey[k]    = 1'b0;
            end else if (x_valid) begin
                bit hit;
                if (accn[k] < 64) begin
                    acc[k][accn[k]] = x_in;
                    accn[k]++;
                end
                hit = (accn[k] >= 4);
                if (hit) begin
                    for (int j = 0; j < 4; j++) begin
                        if (acc[k][accn[k] - 4 + j] != m_pat[k][3 - j]) hit = 1'b0;
                    end
                end
                ey[k] = hit;
                if (hit) begin
                    if (ecnt[k] < m_cap[k]) ecnt[k]++;
                    if (!m_ov[k]) accn[k] = 0;
                end
            end else begin
                ey[k] = 1'b0;
            end
        end
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pulses[3] = '{0, 0, 0};

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cmp_all();
        logic yv[3];
        int   cv[3];
        yv = '{y_ov, y_nov, y_sat};
        cv = '{int'(c_ov), int'(c_nov), int'(c_sat)};
        for (int k = 0; k < 3; k++) begin
            total++;
            if (yv[k] !== ey[k]) begin
                bad++;
                $display("FAIL y_out[%0d] cyc=%0d: got %b expected %b", k, cyc, yv[k], ey[k]);
            end
            if (yv[k] === 1'b1) pulses[k]++;
            total++;
            if (cv[k] != (CNT_ON ? ecnt[k] : 0)) begin
                bad++;
                $display("FAIL match_count[%0d] cyc=%0d: got %0d expected %0d",
                         k, cyc, cv[k], CNT_ON ? ecnt[k] : 0);
            end
        end
    endtask

    // One clock: drive inputs, let the edge happen, compare on the falling edge.
    task automatic tick(input logic r, input logic v, input logic x, input logic l,
                        input logic [3:0] p);
        reset    = r;
        x_valid  = v;
        x_in     = x;
        pat_load = l;
        pat_in   = p;
        @(posedge CLK_TB);
        @(negedge CLK_TB);
        cyc++;
        cmp_all();
        if (r || v || l)
            $display("cyc=%0d rst=%b v=%b x=%b ld=%b pat=%b -> y=%b%b%b cnt=%0d/%0d/%0d",
                     cyc, r, v, x, l, p, y_ov, y_nov, y_sat, c_ov, c_nov, c_sat);
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            tick(1'b0, 1'b1, bits[i], 1'b0, 4'b0000);
            repeat (gap) tick(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
        end
    endtask

    task automatic do_reset();
        tick(1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    endtask

    initial begin
        int b0, b1, b2;
        reset = 1'b1; x_in = 1'b0; x_valid = 1'b0; pat_load = 1'b0; pat_in = 4'b0000;

        // Reset state
        do_reset();
        chk("rst_y_ov", int'(y_ov), 0);
        chk("rst_cnt_ov", int'(c_ov), 0);

        // 1011011: overlapping gives two pulses, non-overlapping one
        b0 = pulses[0]; b1 = pulses[1]; b2 = pulses[2];
        send_bits(16'b1011011, 7, 0);
        idle();
        chk("ovl_pulses", pulses[0] - b0, 2);
        chk("novl_pulses", pulses[1] - b1, 1);
        chk("sat_no_pulse", pulses[2] - b2, 0);
        chk("ovl_count", int'(c_ov), CNT_ON ? 2 : 0);
        chk("novl_count", int'(c_nov), CNT_ON ? 1 : 0);

        // Gaps of three invalid cycles stall but do not clear the window
        do_reset();
        b0 = pulses[0];
        send_bits(16'b1011, 4, 3);
        chk("gap_pulses", pulses[0] - b0, 1);

        // Reset on the completing edge suppresses the pulse and clears history
        do_reset();
        b0 = pulses[0]; b1 = pulses[1];
        send_bits(16'b101, 3, 0);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
        chk("rst_mid_y", int'(y_ov), 0);
        send_bits(16'b1, 1, 0);
        idle();
        chk("rst_mid_pulses", pulses[0] - b0 + pulses[1] - b1, 0);
        chk("rst_mid_count", int'(c_ov), 0);

        // Load on the completing edge wins; old bits do not contribute afterwards
        b0 = pulses[0];
        send_bits(16'b101, 3, 0);
        tick(1'b0, 1'b1, 1'b1, 1'b1, 4'b1011);
        send_bits(16'b1, 1, 0);
        chk("load_win_pulses", pulses[0] - b0, 0);
        send_bits(16'b011, 3, 0);
        chk("load_after_pulse", pulses[0] - b0, 1);

        // Load 0110, then 0110 matches and 1011 no longer does
        do_reset();
        tick(1'b0, 1'b0, 1'b0, 1'b1, 4'b0110);
        b0 = pulses[0]; b1 = pulses[1]; b2 = pulses[2];
        send_bits(16'b0110, 4, 0);
        chk("load_ovl_hit", pulses[0] - b0, 1);
        chk("load_novl_hit", pulses[1] - b1, 1);
        chk("load_sat_hit", pulses[2] - b2, 1);
        b0 = pulses[0];
        send_bits(16'b1011, 4, 0);
        idle();
        chk("load_old_pat", pulses[0] - b0, 0);

        // All-ones pattern fed eight ones: back-to-back pulses, 2-bit counter saturates
        do_reset();
        b2 = pulses[2];
        send_bits(16'b11111111, 8, 0);
        chk("sat_back2back", int'(y_sat), 1);
        idle();
        chk("sat_pulses", pulses[2] - b2, 5);
        chk("sat_count", int'(c_sat), CNT_ON ? 3 : 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised serial sequence detector, the next generation of the team's fixed-pattern `FSM_*` detectors. It samples a one-bit input stream under a valid qualifier and compares the last `PAT_LEN` accepted bits against a pattern register. On a match it raises a one-cycle registered pulse. The pattern is reloadable at run time, and overlapping or non-overlapping detection is selectable by parameter.

## Interface
Parameters:
- `PAT_LEN`, 4, pattern length in bits, 2..16.
- `PATTERN`, 4'b1011, reset value of the pattern register; the MSB is the first bit in time.
- `OVERLAP`, 1, 1 = overlapping matches allowed, 0 = window restarts after a match.
- `CNT_W`, 8, width of the match counter.

Ports:
- `CLK`, input, 1, clock; all state updates on the rising edge.
- `Reset`, input, 1, synchronous, active-high reset.
- `x_in`, input, 1, serial data bit.
- `x_valid`, input, 1, `x_in` is sampled only when this is 1.
- `pat_load`, input, 1, loads `pat_in` into the pattern register.
- `pat_in`, input, `PAT_LEN`, new pattern.
- `y_out`, output, 1, match pulse, registered.
- `match_count`, output, `CNT_W`, saturating match counter.

## Operation
- Internal state:
  - `hist[PAT_LEN-1:0]` holds the accepted bits.
  - `fill` counts accepted bits, 0..`PAT_LEN`, and saturates at `PAT_LEN`.
  - `pat` is the pattern register.
  - `cnt` is the match counter.
- Control FSM states:
  - FILL: `fill < PAT_LEN`.
  - ARMED: `fill == PAT_LEN`.
- Edge priority: Reset > `pat_load` > `x_valid`.
- Reset: `pat <= PATTERN`, `hist <= 0`, `fill <= 0`, `y_out <= 0`, `cnt <= 0`. State goes to FILL.
- `pat_load=1`: `pat <= pat_in`, `hist <= 0`, `fill <= 0`, `y_out <= 0`. `x_in` is ignored that cycle. `cnt` is kept.
- `x_valid=1`, no load:
  - Shift: `next_hist = {hist[PAT_LEN-2:0], x_in}`.
  - `fill` increments unless it is already saturated.
  - Match condition: `next_hist == pat` and (`fill+1 >= PAT_LEN`).
  - On a match: `y_out <= 1`.
  - On a match with `OVERLAP=0`: `fill <= 0` and the state returns to FILL. `hist` is still updated.
  - On a match with `OVERLAP=1`: `fill` stays at `PAT_LEN` and the state stays ARMED.
- `y_out` is 0 on every edge that is not a match, including edges with `x_valid=0`.
- Bits accepted before a reset or load never contribute to a later match.

## Timing
- Latency: `y_out` goes high in the cycle after the edge that samples the last matching bit. The pulse is exactly one cycle wide per match.
- Gaps in `x_valid` stall the window. Non-valid cycles neither shift nor clear it.
- Back-to-back matches with `OVERLAP=1` give `y_out` high on consecutive cycles, for example an all-ones pattern fed all ones.
- Reset asserted mid-stream clears `y_out` on that same edge, so no pulse appears the next cycle. The first possible match is `PAT_LEN` valid bits after Reset deasserts.
- `pat_load` together with a completing bit: the load wins and no pulse is produced.
- `match_count` updates on the same edge as `y_out`. It counts +1 per match and holds at 2^`CNT_W`-1.

## Configuration
- Macro: `SEQDET_MATCH_COUNT_EN`.
- Defined: `cnt` is implemented as described above, and `match_count` = `cnt`.
- Undefined: no counter logic is built, and `match_count` is tied to all zeros. The port list is unchanged.

## Structure
- Package `seqdet_pkg` holds:
  - the state enum `seqdet_state_t` {FILL, ARMED};
  - the constants `SEQDET_MAX_LEN = 16` and `SEQDET_MIN_LEN = 2`, used for elaboration-time parameter checks.
- Sub-module `seqdet_sat_counter` (generic saturating counter with `WIDTH` and an increment enable) is instantiated only under the macro.

## Test plan
- `PAT_LEN=4`, `PATTERN=1011`, `OVERLAP=1`, valid bits 1,0,1,1,0,1,1 → `y_out` pulses after bit 4 and after bit 7; `match_count`=2.
- Same stream with `OVERLAP=0` → a single pulse after bit 4; `match_count`=1.
- Stream 1,0,1,1 with `x_valid` low for 3 cycles between each bit → one pulse, on the cycle after the 4th valid bit.
- Reset asserted on the edge that samples the 4th bit of 1011 → no pulse; `y_out`=0 and `match_count`=0 afterwards.
- `pat_load` with `pat_in`=0110, then stream 0,1,1,0 → pulse after bit 4; stream 1,0,1,1 after that → no pulse.
- `CNT_W=2`, all-ones pattern, 8 valid ones with `OVERLAP=1` → 5 pulses; `match_count` saturates at 3. With the macro undefined, `match_count` stays 0.
